vend_credit_ctrl: RTL and testbench

- Owns the vending machine's credit register (total_money). It accepts coin pulses, applies purchase deductions from the vend FSM, and sequences change refunds through a coin hopper.
- Coin-out uses a req/ack handshake, one coin per handshake, with greedy largest-first selection.
- Sits between the coin acceptor/hopper hardware and the vend FSM. Its total_money output feeds the FSM directly.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_credit_ctrl_change_picker.sv | 26 ++
 rtl/vend_credit_ctrl.sv | 132 +++++++++++++
 tb/tb_vend_credit_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending machine credit path: coin encodings,
// credit controller states and the cents-valued money type.
package vend_pkg;

    typedef logic [7:0] money_t;

    typedef enum logic [1:0] {
        COIN_5   = 2'b00,
        COIN_10  = 2'b01,
        COIN_25  = 2'b10,
        COIN_100 = 2'b11
    } coin_e;

    typedef enum logic [1:0] {
        CREDIT,
        REFUND_SEL,
        REFUND_WAIT,
        ERROR
    } credit_state_e;

    function automatic money_t coin_value(input coin_e c);
        case (c)
            COIN_5:  return 8'd5;
            COIN_10: return 8'd10;
            COIN_25: return 8'd25;
            default: return 8'd100;
        endcase
    endfunction

endpackage

// File: rtl/vend_credit_ctrl_change_picker.sv
// Greedy change selection: largest stocked denomination that fits the credit.
module change_picker
    import vend_pkg::*;
(
    input  logic [7:0] credit,
    input  logic [2:0] hopper_empty,
    output logic       found,
    output coin_e      coin
);

    always_comb begin
        found = 1'b0;
        coin  = COIN_5;
        if (credit >= 8'd25 && !hopper_empty[2]) begin
            found = 1'b1;
            coin  = COIN_25;
        end else if (credit >= 8'd10 && !hopper_empty[1]) begin
            found = 1'b1;
            coin  = COIN_10;
        end else if (credit >= 8'd5 && !hopper_empty[0]) begin
            found = 1'b1;
            coin  = COIN_5;
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit register owner: accepts coins, applies purchase deductions and
// sequences change refunds through the coin hopper one coin per handshake.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned MAX_CREDIT  = 200,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_reject,
    input  logic       deduct_en,
    input  logic [7:0] new_credit,
    input  logic       refund_req,
    output logic [7:0] total_money,
    output logic       busy,
    output logic       hopper_req,
    output logic [1:0] hopper_coin,
    input  logic       hopper_ack,
    input  logic [2:0] hopper_empty,
    output logic       refund_done,
    output logic       refund_error
);

    localparam logic [8:0] MAX9    = 9'(MAX_CREDIT);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    credit_state_e state_q, state_d;
    money_t        money_q, money_d;
    coin_e         coin_q, coin_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          reject_q, reject_d;
    logic          done_q, done_d;

    money_t        coin_val;
    logic [8:0]    coin_sum;
    logic          pick_found;
    coin_e         pick_coin;

    assign coin_val = coin_value(coin_e'(coin_type));
    assign coin_sum = {1'b0, money_q} + {1'b0, coin_val};

    change_picker u_picker (
        .credit       (money_q),
        .hopper_empty (hopper_empty),
        .found        (pick_found),
        .coin         (pick_coin)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= CREDIT;
            money_q  <= '0;
            coin_q   <= COIN_5;
            cnt_q    <= '0;
            reject_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            money_q  <= money_d;
            coin_q   <= coin_d;
            cnt_q    <= cnt_d;
            reject_q <= reject_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        money_d  = money_q;
        coin_d   = coin_q;
        cnt_d    = cnt_q;
        reject_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            CREDIT: begin
                if (deduct_en) begin
                    if (new_credit <= money_q) money_d = new_credit;
                    reject_d = coin_valid;
                end else if (refund_req) begin
                    if (money_q == '0) done_d = 1'b1;
                    else               state_d = REFUND_SEL;
                    reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (coin_sum <= MAX9) money_d = coin_sum[7:0];
                    else                  reject_d = 1'b1;
                end
            end
            REFUND_SEL: begin
                reject_d = coin_valid;
                if (money_q == '0) begin
                    done_d  = 1'b1;
                    state_d = CREDIT;
                end else if (pick_found) begin
                    coin_d  = pick_coin;
                    cnt_d   = '0;
                    state_d = REFUND_WAIT;
                end else begin
                    state_d = ERROR;
                end
            end
            REFUND_WAIT: begin
                reject_d = coin_valid;
                // picker guaranteed coin <= credit, so this cannot underflow
                if (hopper_ack) begin
                    money_d = money_q - coin_value(coin_q);
                    state_d = REFUND_SEL;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ERROR: begin
                reject_d = coin_valid;
                if (refund_req) state_d = REFUND_SEL;
            end
            default: state_d = CREDIT;
        endcase
    end

    assign total_money  = money_q;
    assign coin_reject  = reject_q;
    assign refund_done  = done_q;
    assign busy         = (state_q == REFUND_SEL) || (state_q == REFUND_WAIT);
    assign hopper_req   = (state_q == REFUND_WAIT);
    assign refund_error = (state_q == ERROR);
    assign hopper_coin  = coin_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: vector table, directed refund
// scenarios and randomized traffic against a cents-level reference model.
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = '0;
    logic       coin_reject;
    logic       deduct_en = 1'b0;
    logic [7:0] new_credit = '0;
    logic       refund_req = 1'b0;
    logic [7:0] total_money;
    logic       busy;
    logic       hopper_req;
    logic [1:0] hopper_coin;
    logic       hopper_ack = 1'b0;
    logic [2:0] hopper_empty = '0;
    logic       refund_done;
    logic       refund_error;

    int errors = 0;
    int checks = 0;

    // reference model state: mode 0 idle/credit, 1 choosing, 2 awaiting hopper, 3 stuck
    int m_total, m_mode, m_coin, m_waited, m_rej, m_done;

    vend_credit_ctrl #(.MAX_CREDIT(200), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_reject(coin_reject), .deduct_en(deduct_en), .new_credit(new_credit),
        .refund_req(refund_req), .total_money(total_money), .busy(busy),
        .hopper_req(hopper_req), .hopper_coin(hopper_coin), .hopper_ack(hopper_ack),
        .hopper_empty(hopper_empty), .refund_done(refund_done), .refund_error(refund_error)
    );

    always #5 clk = ~clk;

    function automatic int val(input int ct);
        case (ct)
            0: return 5;
            1: return 10;
            2: return 25;
            default: return 100;
        endcase
    endfunction

    function automatic int pick(input int credit, input int he);
        int dens[3] = '{25, 10, 5};
        int tube[3] = '{2, 1, 0};
        for (int i = 0; i < 3; i++)
            if (dens[i] <= credit && ((he >> tube[i]) & 1) == 0) return dens[i];
        return 0;
    endfunction

    function automatic int code_of(input int cents);
        return (cents == 5) ? 0 : (cents == 10) ? 1 : 2;
    endfunction

    function automatic int cents_of(input logic [1:0] c);
        return val(int'(c));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int cv, input int ct, input int de, input int nc,
                              input int rr, input int ack, input int he);
        int d;
        m_rej  = 0;
        m_done = 0;
        case (m_mode)
            0: begin
                if (de != 0) begin
                    if (nc <= m_total) m_total = nc;
                    m_rej = (cv != 0);
                end else if (rr != 0) begin
                    if (m_total == 0) m_done = 1;
                    else              m_mode = 1;
                    m_rej = (cv != 0);
                end else if (cv != 0) begin
                    if (m_total + val(ct) <= 200) m_total += val(ct);
                    else                          m_rej = 1;
                end
            end
            1: begin
                m_rej = (cv != 0);
                if (m_total == 0) begin
                    m_done = 1;
                    m_mode = 0;
                end else begin
                    d = pick(m_total, he);
                    if (d > 0) begin
                        m_coin = d;
                        m_waited = 0;
                        m_mode = 2;
                    end else m_mode = 3;
                end
            end
            2: begin
                m_rej = (cv != 0);
                if (ack != 0) begin
                    m_total -= m_coin;
                    m_mode = 1;
                end else begin
                    m_waited++;
                    if (m_waited >= 16) m_mode = 3;
                end
            end
            default: begin
                m_rej = (cv != 0);
                if (rr != 0) m_mode = 1;
            end
        endcase
    endtask

    task automatic cycle(input int rst, input int cv, input int ct, input int de,
                         input int nc, input int rr, input int ack, input int he);
        reset        = (rst != 0);
        coin_valid   = (cv != 0);
        coin_type    = 2'(ct);
        deduct_en    = (de != 0);
        new_credit   = 8'(nc);
        refund_req   = (rr != 0);
        hopper_ack   = (ack != 0);
        hopper_empty = 3'(he);
        @(posedge clk);
        if (rst != 0) begin
            m_total = 0; m_mode = 0; m_coin = 5; m_waited = 0; m_rej = 0; m_done = 0;
        end else begin
            model_step(cv, ct, de, nc, rr, ack, he);
        end
        #1;
        chk("total_money", int'(total_money), m_total);
        chk("coin_reject", int'(coin_reject), m_rej);
        chk("refund_done", int'(refund_done), m_done);
        chk("busy", int'(busy), int'(m_mode == 1 || m_mode == 2));
        chk("hopper_req", int'(hopper_req), int'(m_mode == 2));
        chk("refund_error", int'(refund_error), int'(m_mode == 3));
        if (m_mode == 2) chk("hopper_coin", int'(hopper_coin), code_of(m_coin));
    endtask

    task automatic idle(input int he);
        cycle(0, 0, 0, 0, 0, 0, 0, he);
    endtask

    task automatic coin(input int ct);
        cycle(0, 1, ct, 0, 0, 0, 0, 0);
    endtask

    // Pulse refund_req, ack each hopper request on its third cycle, and
    // compare the dispensed denominations with the expected list.
    task automatic do_refund(input string tag, input int he, input int n,
                             input int c0, input int c1, input int c2);
        int got[$];
        int exp[3];
        int w;
        bit done;
        bit a;
        exp = '{c0, c1, c2};
        cycle(0, 0, 0, 0, 0, 1, 0, he);
        w = 0;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            a = 0;
            if (hopper_req) begin
                w++;
                if (w == 3) begin
                    a = 1;
                    got.push_back(cents_of(hopper_coin));
                    w = 0;
                end
            end
            if (busy !== 1'b1 && !done) chk({tag, "_busy"}, int'(busy), 1);
            cycle(0, 0, 0, 0, 0, 0, int'(a), he);
            if (refund_done) done = 1;
        end
        chk({tag, "_done_seen"}, int'(done), 1);
        chk({tag, "_coin_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk({tag, "_coin"}, got[i], exp[i]);
        chk({tag, "_final_total"}, int'(total_money), 0);
    endtask

    typedef struct {
        int cv;
        int ct;
        int de;
        int nc;
        int total;
        int rej;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int he;
        int n;
        bit seen_err;

        tbl[0]  = '{1, 2, 0, 0,   25,  0};
        tbl[1]  = '{1, 1, 0, 0,   35,  0};
        tbl[2]  = '{1, 0, 0, 0,   40,  0};
        tbl[3]  = '{1, 3, 0, 0,   140, 0};
        tbl[4]  = '{1, 2, 0, 0,   165, 0};
        tbl[5]  = '{1, 2, 0, 0,   190, 0};
        tbl[6]  = '{1, 0, 0, 0,   195, 0};
        tbl[7]  = '{1, 3, 0, 0,   195, 1};
        tbl[8]  = '{1, 0, 0, 0,   200, 0};
        tbl[9]  = '{1, 0, 0, 0,   200, 1};
        tbl[10] = '{0, 0, 1, 100, 100, 0};
        tbl[11] = '{1, 2, 1, 35,  35,  1};
        tbl[12] = '{0, 0, 1, 50,  35,  0};
        tbl[13] = '{0, 0, 0, 0,   35,  0};

        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_total", int'(total_money), 0);
        chk("reset_outputs", int'({coin_reject, busy, hopper_req, refund_done, refund_error}), 0);

        for (int i = 0; i < 14; i++) begin
            cycle(0, tbl[i].cv, tbl[i].ct, tbl[i].de, tbl[i].nc, 0, 0, 0);
            chk("tbl_total", int'(total_money), tbl[i].total);
            chk("tbl_reject", int'(coin_reject), tbl[i].rej);
        end

        // refund of zero credit completes immediately
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        chk("zero_refund_done", int'(refund_done), 1);
        chk("zero_refund_busy", int'(busy), 0);

        // 40 cents, all tubes stocked
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        coin(2); coin(1); coin(0);
        do_refund("r40", 0, 3, 25, 10, 5);

        // 15 cents, dime tube empty
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        coin(1); coin(0);
        do_refund("r15", 3'b010, 3, 5, 5, 5);

        // 10 cents, nickel and dime tubes empty, then retry after restock
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        coin(1);
        cycle(0, 0, 0, 0, 0, 1, 0, 3'b011);
        idle(3'b011);
        idle(3'b011);
        chk("empty_err", int'(refund_error), 1);
        chk("empty_err_total", int'(total_money), 10);
        do_refund("retry", 0, 1, 10, 0, 0);
        chk("retry_err_clear", int'(refund_error), 0);

        // 30 cents, hopper never acknowledges
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        coin(2); coin(0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0);
        n = 0;
        seen_err = 0;
        for (int i = 0; i < 60 && !seen_err; i++) begin
            idle(0);
            if (hopper_req) n++;
            if (refund_error) seen_err = 1;
        end
        chk("timeout_err_seen", int'(seen_err), 1);
        chk("timeout_req_cycles", n, 16);
        chk("timeout_total", int'(total_money), 30);
        cycle(0, 1, 0, 0, 0, 0, 1, 0);
        chk("err_coin_reject", int'(coin_reject), 1);
        chk("err_ack_ignored", int'(total_money), 30);

        // randomized traffic against the model
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        he = 0;
        for (int i = 0; i < 4000; i++) begin
            int rst, cv, ct, de, nc, rr, ack;
            rst = ($urandom % 400 == 0) ? 1 : 0;
            cv  = ($urandom % 3 == 0) ? 1 : 0;
            ct  = int'($urandom % 4);
            de  = ($urandom % 12 == 0) ? 1 : 0;
            nc  = ($urandom % 4 == 0) ? int'($urandom % 256) : int'($urandom_range(0, m_total));
            rr  = ($urandom % 15 == 0) ? 1 : 0;
            ack = hopper_req ? (($urandom % 3 == 0) ? 1 : 0) : (($urandom % 20 == 0) ? 1 : 0);
            if ($urandom % 40 == 0) he = int'($urandom % 8);
            cycle(rst, cv, ct, de, nc, rr, ack, he);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
